cp0_timer_ctrl: RTL and testbench

//  Parametrised next-generation system coprocessor 0 for the pipelined MIPS core: SR/Cause/EPC/PrID

---
 rtl/cp0_timer_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cp0_timer_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: system coprocessor 0 for the pipelined MIPS core.
// Holds SR, Cause, EPC and PrID, software and hardware interrupts, and an optional Count/Compare
// timer. Define CP0_TIMER_EN to build the timer; without it Count/Compare read 0 and TI stays 0.
module cp0_timer_ctrl #(
  parameter int unsigned NUM_HWINT  = 6,
  parameter int unsigned TIMER_LINE = NUM_HWINT - 1,
  parameter int unsigned COUNT_DIV  = 1,
  parameter logic [31:0] PRID       = 32'h4441_7A9F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WE,
  input  logic [4:0]           A,
  input  logic [31:0]          Din,
  output logic [31:0]          Dout,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCout,
  output logic                 Req,
  output logic                 TimerIrq
);

  localparam int unsigned HwLo = 10;
  localparam int unsigned HwHi = 9 + NUM_HWINT;
  // Writable SR bits: IM_hw, IM_sw, EXL, IE.
  localparam logic [31:0] SrMask = ((32'd1 << (10 + NUM_HWINT)) - 32'd1) & ~32'h0000_00FC;

  logic [31:0]          sr_q, sr_d;
  logic                 bd_q, bd_d;
  logic [NUM_HWINT-1:0] ip_hw_q, ip_hw_d;
  logic [1:0]           ip_sw_q, ip_sw_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic [31:0]          epc_q, epc_d;

  logic                 ti;
  logic [NUM_HWINT-1:0] ti_vec, hw_eff;
  logic                 int_req, exc_req, wr_en;
  logic [31:0]          cause_rd, count_rd, compare_rd;

  // Effective hardware lines: external inputs plus the timer flag on its line.
  always_comb begin
    ti_vec             = '0;
    ti_vec[TIMER_LINE] = ti;
    hw_eff             = HWInt | ti_vec;
  end

  assign int_req = (|({hw_eff, ip_sw_q} & {sr_q[HwHi:HwLo], sr_q[9:8]})) & sr_q[0] & ~sr_q[1];
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_q[1];
  assign Req     = int_req | exc_req;
  // A taken request drops any mtc0 in the same cycle.
  assign wr_en   = WE & ~Req;

  // Next state for SR/Cause/EPC: exception entry first, otherwise mtc0 and eret.
  always_comb begin
    sr_d       = sr_q;
    bd_d       = bd_q;
    ip_hw_d    = hw_eff;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      sr_d[1]    = 1'b1;
      bd_d       = BDIn;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      epc_d      = BDIn ? (VPC - 32'd4) : VPC;
    end else begin
      if (WE) begin
        case (A)
          5'd12:   sr_d    = Din & SrMask;
          5'd13:   ip_sw_d = Din[9:8];
          5'd14:   epc_d   = Din;
          default: ;
        endcase
      end
      if (EXLClr) sr_d[1] = 1'b0;
    end
  end

  // Core CP0 state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      sr_q       <= sr_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

`ifdef CP0_TIMER_EN
  localparam int unsigned PresW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(COUNT_DIV - 1);

  logic [31:0]      count_q, count_d, compare_q, compare_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic             hit_q, hit_d, ti_q, ti_d, count_step;

  // Timer next state; hit_q delays TI by one cycle after Count reaches Compare.
  always_comb begin
    count_d    = count_q;
    compare_d  = compare_q;
    presc_d    = presc_q;
    ti_d       = ti_q;
    count_step = 1'b0;
    if (wr_en && (A == 5'd9)) begin
      count_d    = Din;
      presc_d    = '0;
      count_step = 1'b1;
    end else if (presc_q == PresLast) begin
      presc_d    = '0;
      count_d    = count_q + 32'd1;
      count_step = 1'b1;
    end else begin
      presc_d = presc_q + PresW'(1);
    end
    if (wr_en && (A == 5'd11)) compare_d = Din;
    hit_d = count_step & (count_d == compare_d);
    if (wr_en && (A == 5'd11)) ti_d = 1'b0;
    else if (hit_q)            ti_d = 1'b1;
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      presc_q   <= '0;
      hit_q     <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      presc_q   <= presc_d;
      hit_q     <= hit_d;
      ti_q      <= ti_d;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  logic unused_cfg;
  assign unused_cfg = (COUNT_DIV == 0);
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  // Cause register view.
  always_comb begin
    cause_rd            = '0;
    cause_rd[31]        = bd_q;
    cause_rd[30]        = ti;
    cause_rd[HwHi:HwLo] = ip_hw_q;
    cause_rd[9:8]       = ip_sw_q;
    cause_rd[6:2]       = exc_code_q;
  end

  // mfc0 read mux.
  always_comb begin
    case (A)
      5'd9:    Dout = count_rd;
      5'd11:   Dout = compare_rd;
      5'd12:   Dout = sr_q;
      5'd13:   Dout = cause_rd;
      5'd14:   Dout = epc_q;
      5'd15:   Dout = PRID;
      default: Dout = '0;
    endcase
  end

  assign EPCout   = epc_q;
  assign TimerIrq = ti;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Scoreboard bench for cp0_timer_ctrl; timer checks are built when CP0_TIMER_EN is defined.
module tb_cp0_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WE = 1'b0;
  logic [4:0]  A = '0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic [31:0] VPC = '0;
  logic        BDIn = 1'b0;
  logic [4:0]  ExcCodeIn = '0;
  logic [5:0]  HWInt = '0;
  logic        EXLClr = 1'b0;
  logic [31:0] EPCout;
  logic        Req;
  logic        TimerIrq;

  cp0_timer_ctrl u_dut (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .Din(Din), .Dout(Dout), .VPC(VPC), .BDIn(BDIn),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr), .EPCout(EPCout), .Req(Req),
    .TimerIrq(TimerIrq)
  );

`ifdef CP0_TIMER_EN
  logic [31:0] dout4, epc4;
  logic        req4, ti4;

  cp0_timer_ctrl #(.COUNT_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .Din(Din), .Dout(dout4), .VPC(VPC), .BDIn(BDIn),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr), .EPCout(epc4), .Req(req4),
    .TimerIrq(ti4)
  );
`endif

  always #5 clk = ~clk;

  // kind: 0 Dout, 1 Req, 2 TimerIrq, 3 EPCout, 4 Dout of the divide-by-4 instance
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    WE  = 1'b1;
    A   = a;
    Din = d;
    tick();
    WE  = 1'b0;
    Din = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    A = a;
    push(0, exp, name);
    tick();
  endtask

  // Monitor: every entry queued during a cycle is compared at the following falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = Dout;
        1:       act = {31'd0, Req};
        2:       act = {31'd0, TimerIrq};
        3:       act = EPCout;
`ifdef CP0_TIMER_EN
        4:       act = dout4;
`endif
        default: act = 32'hxxxx_xxxx;
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    push(1, 0, "rst_req");
    push(2, 0, "rst_ti");
    push(3, 0, "rst_epcout");
    rd(9, 32'h0, "rst_count");
    rd(11, 32'h0, "rst_compare");
    rd(12, 32'h0, "rst_sr");
    rd(13, 32'h0, "rst_cause");
    rd(14, 32'h0, "rst_epc");
    rd(15, 32'h4441_7A9F, "rst_prid");

    // Hardware interrupt on line 0
    mtc0(12, 32'h0000_0401);
    HWInt = 6'b000001;
    VPC   = 32'h1000;
    A     = 12;
    push(0, 32'h401, "t1_sr_pre");
    push(1, 1, "t1_req");
    tick();
    A = 13;
    push(0, 32'h400, "t1_cause");
    push(1, 0, "t1_req_exl");
    tick();
    HWInt = '0;
    VPC   = '0;
    rd(12, 32'h403, "t1_sr_exl");
    rd(14, 32'h1000, "t1_epc");
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    push(1, 0, "t1_no_req");
    rd(12, 32'h401, "t1_sr_eret");
    mtc0(12, 32'h0);

    // Exception in a delay slot
    ExcCodeIn = 5'd4;
    BDIn      = 1'b1;
    VPC       = 32'h3008;
    push(1, 1, "t2_req");
    tick();
    ExcCodeIn = '0;
    BDIn      = 1'b0;
    VPC       = '0;
    push(3, 32'h3004, "t2_epcout");
    rd(14, 32'h3004, "t2_epc");
    rd(13, 32'h8000_0010, "t2_cause");
    rd(12, 32'h2, "t2_sr_exl");
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd(12, 32'h0, "t2_sr_eret");

    // Software interrupt 0
    mtc0(12, 32'h0000_0101);
    WE  = 1'b1;
    A   = 13;
    Din = 32'h100;
    push(1, 0, "t3_req_wr");
    tick();
    WE  = 1'b0;
    Din = '0;
    VPC = 32'h2000;
    push(1, 1, "t3_req_sw");
    tick();
    VPC = '0;
    rd(13, 32'h100, "t3_cause");
    rd(14, 32'h2000, "t3_epc");
    mtc0(13, 32'h0);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    push(1, 0, "t3_no_req");
    rd(12, 32'h101, "t3_sr");

    // Req beats mtc0; interrupt beats exception code
    mtc0(12, 32'h0);
    ExcCodeIn = 5'd10;
    VPC       = 32'h5000;
    WE        = 1'b1;
    A         = 14;
    Din       = 32'h1234;
    push(1, 1, "t6_req_we");
    tick();
    WE        = 1'b0;
    Din       = '0;
    ExcCodeIn = '0;
    VPC       = '0;
    rd(14, 32'h5000, "t6_epc");
    rd(13, 32'h28, "t6_cause");
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    mtc0(12, 32'h0000_0801);
    HWInt     = 6'b000010;
    ExcCodeIn = 5'd8;
    VPC       = 32'h6000;
    push(1, 1, "t6_req_both");
    tick();
    HWInt     = '0;
    ExcCodeIn = '0;
    VPC       = '0;
    rd(13, 32'h800, "t6_cause_int");
    rd(13, 32'h0, "t6_cause_iphw_clr");
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    mtc0(12, 32'h0);

    // Write masks, read-only and unmapped registers
    mtc0(12, 32'hFFFF_FFFF);
    rd(12, 32'h0000_FF03, "sr_mask");
    mtc0(12, 32'h0);
    mtc0(15, 32'h0);
    rd(15, 32'h4441_7A9F, "prid_ro");
    mtc0(3, 32'hDEAD_BEEF);
    rd(3, 32'h0, "unknown_a");

`ifdef CP0_TIMER_EN
    // Compare hit raises TI one cycle after Count reaches it
    mtc0(11, 32'd5);
    mtc0(9, 32'd0);
    repeat (5) tick();
    push(2, 0, "t4_ti_early");
    tick();
    push(2, 1, "t4_ti_set");
    rd(9, 32'd6, "t4_count");
    mtc0(12, 32'h0000_8001);
    VPC = 32'h7000;
    push(1, 1, "t4_req_timer");
    tick();
    VPC = '0;
    push(2, 1, "t4_ti_hold");
    mtc0(11, 32'h8000_0000);
    push(2, 0, "t4_ti_clr");
    EXLClr = 1'b1;
    mtc0(12, 32'h0);
    EXLClr = 1'b0;

    // Count wrap, and divide-by-4 prescaler in the second instance
    mtc0(9, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      A = 9;
      push(0, (i == 0) ? 32'hFFFF_FFFF : 32'(i - 1), "t5_wrap");
      push(4, (i < 4) ? 32'hFFFF_FFFF : 32'h0, "t5_div4");
      tick();
    end
`else
    // No timer: Count/Compare read 0 and TI never rises
    mtc0(11, 32'd5);
    mtc0(9, 32'd5);
    push(2, 0, "notimer_ti");
    rd(9, 32'h0, "notimer_count");
    rd(11, 32'h0, "notimer_compare");
`endif

    // Reset in the middle of operation
    mtc0(14, 32'h0000_ABCD);
    mtc0(13, 32'h300);
    mtc0(12, 32'h0000_0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(13, 32'h0, "midrst_cause");
    rd(14, 32'h0, "midrst_epc");
    rd(12, 32'h0, "midrst_sr");

    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
